// File: rtl/deit_tile_sched.sv
// deit_tile_sched: sequences one matrix job on deit_core.
//
// A job is N output tiles. Each output tile runs K reduction passes, and then
// drains M accumulator rows to the output stream.
// - The first K pass of each N tile overwrites the accumulator.
// - Each later K pass of that N tile accumulates into it.
//
// Ports
//   clk, rst_n                 clock, async active-low reset
//   ap_start/ap_idle/ap_done   job control; ap_err flags a rejected config
//                              and stays set until the next accepted start
//   cfg_m_rows/k/n_tiles       job shape, latched on an accepted ap_start
//   core_start/core_done       one-cycle handshake with deit_core
//   core_compute_cycles        latched M, zero-extended
//   core_acc_mode              0 = overwrite, 1 = accumulate
//   cur_k_tile/cur_n_tile      buffer tile selects
//   acc_rd_en/addr/data        accumulator read; data is valid one cycle
//                              after acc_rd_en
//   out_valid/ready/data/row   result row stream
//   out_last                   last row of the last N tile
//
// State   | meaning
// IDLE    | waiting for ap_start
// CHECK   | validate the latched configuration
// KSTART  | pulse core_start for the current K tile
// KWAIT   | wait for core_done
// DRD     | issue the accumulator read for the current row
// DCAP    | capture the read data into the output register
// DOUT    | present the row until out_ready
// DONE    | one-cycle ap_done
module deit_tile_sched #(
  parameter int ARRAY_COL  = 16,
  parameter int ADDR_WIDTH = 8,
  parameter int TILE_W     = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    ap_start,
  input  logic [ADDR_WIDTH:0]     cfg_m_rows,
  input  logic [TILE_W-1:0]       cfg_k_tiles,
  input  logic [TILE_W-1:0]       cfg_n_tiles,
  output logic                    ap_idle,
  output logic                    ap_done,
  output logic                    ap_err,
  output logic                    core_start,
  output logic [31:0]             core_compute_cycles,
  output logic                    core_acc_mode,
  input  logic                    core_done,
  output logic [TILE_W-1:0]       cur_k_tile,
  output logic [TILE_W-1:0]       cur_n_tile,
  output logic                    acc_rd_en,
  output logic [ADDR_WIDTH-1:0]   acc_rd_addr,
  input  logic [ARRAY_COL*32-1:0] acc_rd_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [ARRAY_COL*32-1:0] out_data,
  output logic [ADDR_WIDTH-1:0]   out_row,
  output logic                    out_last
);

  localparam int DW = ARRAY_COL * 32;
  localparam logic [ADDR_WIDTH:0] M_MAX = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] R_ONE = 1;
  localparam logic [TILE_W-1:0]   T_ONE = 1;

  typedef enum logic [2:0] {
    IDLE, CHECK, KSTART, KWAIT, DRD, DCAP, DOUT, DONE
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH:0]   m_q, m_d;
  logic [TILE_W-1:0]     k_q, k_d;
  logic [TILE_W-1:0]     n_q, n_d;
  logic [TILE_W-1:0]     cur_k_q, cur_k_d;
  logic [TILE_W-1:0]     cur_n_q, cur_n_d;
  // One bit wider than the address, so that M = 2^ADDR_WIDTH needs no wrap.
  logic [ADDR_WIDTH:0]   row_q, row_d;
  logic [DW-1:0]         out_data_q, out_data_d;
  logic                  out_valid_q, out_valid_d;
  logic                  err_q, err_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      m_q         <= '0;
      k_q         <= '0;
      n_q         <= '0;
      cur_k_q     <= '0;
      cur_n_q     <= '0;
      row_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      m_q         <= m_d;
      k_q         <= k_d;
      n_q         <= n_d;
      cur_k_q     <= cur_k_d;
      cur_n_q     <= cur_n_d;
      row_q       <= row_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    m_d         = m_q;
    k_d         = k_q;
    n_d         = n_q;
    cur_k_d     = cur_k_q;
    cur_n_d     = cur_n_q;
    row_d       = row_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    err_d       = err_q;

    case (state_q)
      IDLE: begin
        if (ap_start) begin
          m_d     = cfg_m_rows;
          k_d     = cfg_k_tiles;
          n_d     = cfg_n_tiles;
          cur_k_d = '0;
          cur_n_d = '0;
          row_d   = '0;
          err_d   = 1'b0;
          state_d = CHECK;
        end
      end
      CHECK: begin
        if (m_q == '0 || m_q > M_MAX || k_q == '0 || n_q == '0) begin
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          state_d = KSTART;
        end
      end
      KSTART: state_d = KWAIT;
      KWAIT: begin
        if (core_done) begin
          if (cur_k_q < k_q - T_ONE) begin
            cur_k_d = cur_k_q + T_ONE;
            state_d = KSTART;
          end else begin
            row_d   = '0;
            state_d = DRD;
          end
        end
      end
      DRD: state_d = DCAP;
      DCAP: begin
        out_data_d  = acc_rd_data;
        out_valid_d = 1'b1;
        state_d     = DOUT;
      end
      DOUT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          if (row_q < m_q - R_ONE) begin
            row_d   = row_q + R_ONE;
            state_d = DRD;
          end else if (cur_n_q < n_q - T_ONE) begin
            cur_n_d = cur_n_q + T_ONE;
            cur_k_d = '0;
            row_d   = '0;
            state_d = KSTART;
          end else begin
            state_d = DONE;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign ap_idle             = (state_q == IDLE);
  assign ap_done             = (state_q == DONE);
  assign ap_err              = err_q;
  assign core_start          = (state_q == KSTART);
  assign core_compute_cycles = 32'(m_q);
  // Derived from the tile counter, so it cannot change during a core pass.
  assign core_acc_mode       = (cur_k_q != '0);
  assign cur_k_tile          = cur_k_q;
  assign cur_n_tile          = cur_n_q;
  assign acc_rd_en           = (state_q == DRD);
  assign acc_rd_addr         = row_q[ADDR_WIDTH-1:0];
  assign out_valid           = out_valid_q;
  assign out_data            = out_data_q;
  assign out_row             = row_q[ADDR_WIDTH-1:0];
  assign out_last            = out_valid_q && (row_q == m_q - R_ONE)
                               && (cur_n_q == n_q - T_ONE);

endmodule

// File: tb/tb_deit_tile_sched.sv
module tb_deit_tile_sched;
  localparam int AC = 16;
  localparam int AW = 8;
  localparam int TW = 8;
  localparam int DW = AC * 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          ap_start = 1'b0;
  logic [AW:0]   cfg_m_rows = '0;
  logic [TW-1:0] cfg_k_tiles = '0;
  logic [TW-1:0] cfg_n_tiles = '0;
  logic          ap_idle, ap_done, ap_err, core_start, core_acc_mode;
  logic [31:0]   core_compute_cycles;
  logic          core_done = 1'b0;
  logic [TW-1:0] cur_k_tile, cur_n_tile;
  logic          acc_rd_en;
  logic [AW-1:0] acc_rd_addr;
  logic [DW-1:0] acc_rd_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic [AW-1:0] out_row;
  logic          out_last;

  deit_tile_sched #(.ARRAY_COL(AC), .ADDR_WIDTH(AW), .TILE_W(TW)) dut (
    .clk(clk), .rst_n(rst_n), .ap_start(ap_start),
    .cfg_m_rows(cfg_m_rows), .cfg_k_tiles(cfg_k_tiles), .cfg_n_tiles(cfg_n_tiles),
    .ap_idle(ap_idle), .ap_done(ap_done), .ap_err(ap_err),
    .core_start(core_start), .core_compute_cycles(core_compute_cycles),
    .core_acc_mode(core_acc_mode), .core_done(core_done),
    .cur_k_tile(cur_k_tile), .cur_n_tile(cur_n_tile),
    .acc_rd_en(acc_rd_en), .acc_rd_addr(acc_rd_addr), .acc_rd_data(acc_rd_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_row(out_row), .out_last(out_last)
  );

  always #5 clk = ~clk;

  typedef struct { bit mode; int k; int n; int cc; } st_t;
  typedef struct { int row; bit last; logic [DW-1:0] data; int cyc; } rw_t;
  typedef struct { bit err; int cyc; } dn_t;
  typedef struct { int m; int k; int n; int lat; int rdy; bit err; int starts; int rows; } vec_t;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int unsigned salt = 0;
  int lat = 3;
  int rdy_pct = 100;
  bit spur_en = 1'b0;
  bit spur_done = 1'b0;
  int cnt = 0;
  st_t st_q[$];
  rw_t rows_q[$];
  dn_t done_q[$];
  int s0, r0, d0, start_cyc;
  int hold_viol = 0;
  int ctl_viol = 0;

  function automatic logic [DW-1:0] pat(input int addr, input int n, input int unsigned s);
    logic [DW-1:0] v;
    for (int c = 0; c < AC; c++) v[c*32 +: 32] = {8'(c), 8'(n), 16'(addr)} ^ 32'(s);
    return v;
  endfunction

  function automatic logic [127:0] pk4(input int a, input int b, input int c, input int d);
    return {32'(a), 32'(b), 32'(c), 32'(d)};
  endfunction

  // Accumulator memory: read data one cycle after acc_rd_en; junk otherwise.
  always @(posedge clk)
    acc_rd_data <= acc_rd_en ? pat(int'(acc_rd_addr), int'(cur_n_tile), salt) : ~pat(0, 0, salt);

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #2;
    out_ready = (int'($urandom_range(99)) < rdy_pct);
  end

  // Core model: done lat cycles after start; optional one spurious done in a stall.
  always @(posedge clk) begin
    #3;
    core_done = 1'b0;
    if (!rst_n) cnt = 0;
    else begin
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) core_done = 1'b1;
      end
      if (core_start) cnt = lat;
      if (spur_en && !spur_done && out_valid && !out_ready) begin
        core_done = 1'b1;
        spur_done = 1'b1;
      end
    end
  end

  wire core_busy = (cnt > 0);

  bit            hold_pend = 1'b0;
  logic [DW-1:0] hold_data;
  logic [AW-1:0] hold_row;
  bit            hold_last;
  bit            ctl_pend = 1'b0;
  bit            cm;
  logic [TW-1:0] ck, cn;

  always @(negedge clk) begin
    if (!rst_n) begin
      hold_pend = 1'b0;
      ctl_pend  = 1'b0;
    end else begin
      if (core_start) st_q.push_back('{core_acc_mode, int'(cur_k_tile), int'(cur_n_tile),
                                       int'(core_compute_cycles)});
      if (out_valid && out_ready) rows_q.push_back('{int'(out_row), out_last, out_data, cyc});
      if (ap_done) done_q.push_back('{ap_err, cyc});
      if (hold_pend && (!out_valid || out_data != hold_data || out_row != hold_row
                        || out_last != hold_last)) hold_viol++;
      hold_pend = out_valid && !out_ready;
      hold_data = out_data;
      hold_row  = out_row;
      hold_last = out_last;
      if (core_start) begin
        cm = core_acc_mode; ck = cur_k_tile; cn = cur_n_tile; ctl_pend = 1'b1;
      end else if (ctl_pend) begin
        if (core_acc_mode != cm || cur_k_tile != ck || cur_n_tile != cn) ctl_viol++;
        if (core_done) ctl_pend = 1'b0;
      end
    end
  end

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_reset(input string nm);
    chk({nm, "_idle"}, ap_idle, 1);
    chk({nm, "_done"}, ap_done, 0);
    chk({nm, "_err"}, ap_err, 0);
    chk({nm, "_cstart"}, core_start, 0);
    chk({nm, "_ccyc"}, core_compute_cycles, 0);
    chk({nm, "_accmode"}, core_acc_mode, 0);
    chk({nm, "_ktile"}, cur_k_tile, 0);
    chk({nm, "_ntile"}, cur_n_tile, 0);
    chk({nm, "_rden"}, acc_rd_en, 0);
    chk({nm, "_valid"}, out_valid, 0);
    chk({nm, "_data"}, out_data, 0);
    chk({nm, "_row"}, out_row, 0);
    chk({nm, "_last"}, out_last, 0);
  endtask

  task automatic start_job(input int m, input int k, input int n);
    @(negedge clk);
    cfg_m_rows  = (AW+1)'(m);
    cfg_k_tiles = TW'(k);
    cfg_n_tiles = TW'(n);
    ap_start    = 1'b1;
    s0 = st_q.size(); r0 = rows_q.size(); d0 = done_q.size(); start_cyc = cyc;
    @(negedge clk);
    ap_start    = 1'b0;
    cfg_m_rows  = (AW+1)'($urandom);
    cfg_k_tiles = TW'($urandom);
    cfg_n_tiles = TW'($urandom);
  endtask

  task automatic wait_done(input string nm);
    int i;
    for (i = 0; i < 20000; i++) begin
      if (ap_done) break;
      @(negedge clk);
    end
    if (i == 20000) chk({nm, "_timeout"}, ap_done, 1);
    repeat (3) @(negedge clk);
  endtask

  task automatic check_job(input string nm, input int m, input int k, input int n,
                           input bit e_err, input int e_starts, input int e_rows);
    int idx, j, diff;
    chk({nm, "_ndone"}, done_q.size() - d0, 1);
    if (done_q.size() > d0) begin
      chk({nm, "_errflag"}, done_q[d0].err, e_err);
      if (e_err) chk({nm, "_errlat_le3"}, (done_q[d0].cyc - start_cyc) <= 3, 1);
      else if (rows_q.size() > r0)
        chk({nm, "_done_after_last"}, done_q[d0].cyc - rows_q[rows_q.size()-1].cyc, 1);
    end
    chk({nm, "_nstarts"}, st_q.size() - s0, e_starts);
    chk({nm, "_nrows"}, rows_q.size() - r0, e_rows);
    chk({nm, "_idle_after"}, ap_idle, 1);
    if (e_err) return;
    idx = 0;
    for (int nn = 0; nn < n; nn++)
      for (int kk = 0; kk < k; kk++) begin
        j = s0 + idx;
        if (j < st_q.size())
          chk({nm, "_start{mode,k,n,cc}"},
              pk4(st_q[j].mode, st_q[j].k, st_q[j].n, st_q[j].cc), pk4(kk != 0, kk, nn, m));
        idx++;
      end
    idx = 0;
    for (int nn = 0; nn < n; nn++)
      for (int rr = 0; rr < m; rr++) begin
        j = r0 + idx;
        if (j < rows_q.size()) begin
          chk({nm, "_row{row,last}"}, pk4(0, 0, rows_q[j].row, rows_q[j].last),
              pk4(0, 0, rr, (nn == n-1) && (rr == m-1)));
          chk({nm, "_rowdata"}, rows_q[j].data, pat(rr, nn, salt));
          if (rr > 0 && j > r0) begin
            diff = rows_q[j].cyc - rows_q[j-1].cyc;
            if (rdy_pct == 100) chk({nm, "_rowperiod"}, diff, 3);
            else chk({nm, "_rowperiod_ge3"}, diff >= 3, 1);
          end
        end
        idx++;
      end
  endtask

  task automatic run_job(input string nm, input int m, input int k, input int n, input int lt,
                         input int rp, input bit e_err, input int e_starts, input int e_rows);
    lat = lt; rdy_pct = rp; salt = $urandom;
    start_job(m, k, n);
    wait_done(nm);
    check_job(nm, m, k, n, e_err, e_starts, e_rows);
  endtask

  vec_t tbl[9];

  initial begin
    int m, k, n, sel, i;
    bit bad;
    tbl[0] = '{32, 3, 2, 40, 100, 1'b0, 6, 64};
    tbl[1] = '{1, 1, 1, 3, 100, 1'b0, 1, 1};
    tbl[2] = '{0, 2, 2, 3, 100, 1'b1, 0, 0};
    tbl[3] = '{257, 1, 1, 3, 100, 1'b1, 0, 0};
    tbl[4] = '{16, 2, 1, 5, 30, 1'b0, 2, 16};
    tbl[5] = '{256, 1, 1, 2, 100, 1'b0, 1, 256};
    tbl[6] = '{5, 0, 3, 3, 100, 1'b1, 0, 0};
    tbl[7] = '{5, 2, 0, 3, 100, 1'b1, 0, 0};
    tbl[8] = '{3, 1, 3, 1, 70, 1'b0, 3, 9};

    #1 rst_n = 1'b0;
    #2 chk_reset("por");
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    for (int t = 0; t < 9; t++)
      run_job($sformatf("tbl%0d", t), tbl[t].m, tbl[t].k, tbl[t].n, tbl[t].lat, tbl[t].rdy,
              tbl[t].err, tbl[t].starts, tbl[t].rows);

    // ap_start re-pulsed in KWAIT (with a different config) and core_done during a stall.
    lat = 15; rdy_pct = 40; salt = $urandom;
    start_job(6, 2, 1);
    for (i = 0; i < 2000; i++) begin
      if (core_busy && !core_start && !core_acc_mode) break;
      @(negedge clk);
    end
    chk("disturb_reach_kwait", i < 2000, 1);
    cfg_m_rows = 9'd3; cfg_k_tiles = 8'd4; cfg_n_tiles = 8'd2;
    ap_start = 1'b1;
    @(negedge clk);
    ap_start = 1'b0;
    spur_en = 1'b1;
    wait_done("disturb");
    check_job("disturb", 6, 2, 1, 1'b0, 2, 6);

    // Asynchronous reset in the middle of k tile 1, then a clean job.
    lat = 30; rdy_pct = 100;
    start_job(8, 2, 1);
    for (i = 0; i < 2000; i++) begin
      if (core_busy && !core_start && core_acc_mode) break;
      @(negedge clk);
    end
    chk("midrst_reach_k1", i < 2000, 1);
    #2 rst_n = 1'b0;
    #1 chk_reset("midrst");
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    run_job("after_rst", 8, 2, 1, 6, 100, 1'b0, 2, 8);

    for (int r = 0; r < 25; r++) begin
      m = $urandom_range(20, 1); k = $urandom_range(3, 1); n = $urandom_range(3, 1);
      if ($urandom_range(7) == 0) begin
        sel = $urandom_range(3);
        if (sel == 0) m = 0;
        else if (sel == 1) m = $urandom_range(511, 257);
        else if (sel == 2) k = 0;
        else n = 0;
      end
      bad = (m == 0) || (m > (1 << AW)) || (k == 0) || (n == 0);
      run_job($sformatf("rnd%0d", r), m, k, n, $urandom_range(8, 1),
              ($urandom_range(3) == 0) ? 100 : $urandom_range(100, 30),
              bad, bad ? 0 : k*n, bad ? 0 : m*n);
    end

    chk("hold_stable_viol", hold_viol, 0);
    chk("ctl_stable_viol", ctl_viol, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

endmodule
